// File: rtl/fft_result_drain.sv
// FFT result drain: buffers accumulated bins in a FIFO and emits them as write bursts.
// Optional DRAIN_ADDR_CHECK_EN enables the sticky bin-index sequence check (o_seq_err).
module fft_result_drain #(
  parameter int DEPTH = 8,
  parameter int BLEN  = 4,
  parameter int BW    = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_start,
  input  logic [11:0]   i_samp_number,
  input  logic [31:0]   i_res_data,
  input  logic [11:0]   i_res_addr,
  input  logic          i_res_valid,
  output logic          o_res_ready,
  output logic [31:0]   o_wdata,
  output logic          o_wvalid,
  input  logic          i_wready,
  output logic [BW-1:0] o_wburst,
  output logic          o_wlast,
  output logic          o_done,
  output logic          o_overflow,
  output logic          o_seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic [11:0]   samp_q, samp_d, wr_cnt_q, wr_cnt_d, beats_q, beats_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [11:0]   remaining, burst_len;

  // i_start flushes the FIFO, so neither side may move the pointers that cycle
  assign push      = i_res_valid && ready_q && !i_start;
  assign pop       = (state_q == S_BURST) && i_wready && !i_start;
  assign remaining = samp_q - wr_cnt_q;
  assign burst_len = (remaining < 12'(BLEN)) ? remaining : 12'(BLEN);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    samp_d   = samp_q;
    wr_cnt_d = wr_cnt_q;
    beats_d  = beats_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (i_res_valid && !ready_q) ovf_d = 1'b1;

    case (state_q)
      S_WAIT: begin
        if (12'(count_q) >= burst_len) begin
          state_d = S_BURST;
          beats_d = burst_len;
        end
      end
      S_BURST: begin
        if (pop) begin
          beats_d  = beats_q - 12'd1;
          wr_cnt_d = wr_cnt_q + 12'd1;
          if (beats_q == 12'd1) state_d = (remaining == 12'd1) ? S_DONE : S_WAIT;
        end
      end
      default: ;
    endcase

    if (i_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wr_cnt_d = '0;
      beats_d  = '0;
      ovf_d    = 1'b0;
      samp_d   = i_samp_number;
      state_d  = (i_samp_number == 12'd0) ? S_DONE : S_WAIT;
    end

    ready_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      samp_q   <= '0;
      wr_cnt_q <= '0;
      beats_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      samp_q   <= samp_d;
      wr_cnt_q <= wr_cnt_d;
      beats_q  <= beats_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_res_data;
  end

`ifdef DRAIN_ADDR_CHECK_EN
  logic [11:0] exp_addr_q;
  logic        seq_err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      exp_addr_q <= '0;
      seq_err_q  <= 1'b0;
    end else if (i_start) begin
      exp_addr_q <= '0;
      seq_err_q  <= 1'b0;
    end else if (push) begin
      exp_addr_q <= exp_addr_q + 12'd1;
      if (i_res_addr != exp_addr_q) seq_err_q <= 1'b1;
    end
  end

  assign o_seq_err = seq_err_q;
`else
  logic unused_addr;
  assign unused_addr = ^i_res_addr;
  assign o_seq_err   = 1'b0;
`endif

  // Outputs decode from registered state only, so they hold while the sink stalls
  assign o_wvalid    = (state_q == S_BURST);
  assign o_wdata     = o_wvalid ? mem_q[rd_ptr_q] : 32'd0;
  assign o_wburst    = o_wvalid ? BW'(beats_q - 12'd1) : '0;
  assign o_wlast     = o_wvalid && (beats_q == 12'd1);
  assign o_done      = (state_q == S_DONE);
  assign o_res_ready = ready_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_fft_result_drain.sv
// Randomized bench for fft_result_drain against a burst-level reference model.
module tb_fft_result_drain;
  localparam int DEPTH = 8;
  localparam int BLEN  = 4;
  localparam int BW    = 4;
`ifdef DRAIN_ADDR_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  logic          clk = 1'b0, nrst = 1'b0, i_start = 1'b0, i_res_valid = 1'b0, i_wready = 1'b0;
  logic [11:0]   i_samp_number = '0, i_res_addr = '0;
  logic [31:0]   i_res_data = '0;
  logic          o_res_ready, o_wvalid, o_wlast, o_done, o_overflow, o_seq_err;
  logic [31:0]   o_wdata;
  logic [BW-1:0] o_wburst;
  int total = 0, bad = 0;

  fft_result_drain #(.DEPTH(DEPTH), .BLEN(BLEN), .BW(BW)) dut (
    .clk(clk), .nrst(nrst), .i_start(i_start), .i_samp_number(i_samp_number),
    .i_res_data(i_res_data), .i_res_addr(i_res_addr), .i_res_valid(i_res_valid),
    .o_res_ready(o_res_ready), .o_wdata(o_wdata), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .o_wburst(o_wburst), .o_wlast(o_wlast), .o_done(o_done), .o_overflow(o_overflow),
    .o_seq_err(o_seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int n);
    i_res_valid   = 1'b0;
    i_start       = 1'b1;
    i_samp_number = 12'(n);
    step();
    i_start = 1'b0;
  endtask

  // Model: bursts cover consecutive chunks of min(BLEN, remaining) results in push order;
  // a burst opens one cycle after the buffered count reaches the chunk length.
  task automatic run_xfer(input int n, input int rdy_pct, input int push_pct);
    logic [31:0] q[$];
    logic [31:0] held;
    int pushed, beats, cyc, occ, bs, len, in_burst, stalled, need;
    pushed = 0; beats = 0; cyc = 0; bs = 0; len = 0; in_burst = 0; stalled = 0; held = '0;
    start_xfer(n);
    while (beats < n && cyc < 30000) begin
      occ = pushed - beats;
      chk("res_ready", o_res_ready, occ < DEPTH);
      chk("wvalid", o_wvalid, in_burst);
      chk("done_early", o_done, 0);
      if (stalled != 0) chk("hold_wdata", o_wdata, held);
      i_wready    = ($urandom_range(99) < rdy_pct);
      i_res_valid = (pushed < n) && o_res_ready && ($urandom_range(99) < push_pct);
      i_res_data  = $urandom;
      i_res_addr  = 12'(pushed);
      stalled = 0;
      need = (n - beats < BLEN) ? n - beats : BLEN;
      if (in_burst != 0) begin
        chk("wdata", o_wdata, (beats < q.size()) ? q[beats] : 32'hx);
        chk("wburst", o_wburst, len - 1 - (beats - bs));
        chk("wlast", o_wlast, (beats - bs) == len - 1);
        if (i_wready) begin
          beats++;
          if (beats - bs == len) in_burst = 0;
        end else begin
          stalled = 1;
          held = o_wdata;
        end
      end else if (occ >= need) begin
        in_burst = 1;
        bs = beats;
        len = need;
      end
      if (i_res_valid) begin
        q.push_back(i_res_data);
        pushed++;
      end
      step();
      cyc++;
    end
    i_res_valid = 1'b0;
    i_wready    = 1'b0;
    chk("beats_done", beats, n);
    chk("done", o_done, 1);
    chk("wvalid_idle", o_wvalid, 0);
    chk("no_overflow", o_overflow, 0);
    chk("no_seq_err", o_seq_err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_res_ready, 1);
    chk({tag, "_wvalid"}, o_wvalid, 0);
    chk({tag, "_wdata"}, o_wdata, 0);
    chk({tag, "_wburst"}, o_wburst, 0);
    chk({tag, "_wlast"}, o_wlast, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
    chk({tag, "_seq"}, o_seq_err, 0);
  endtask

  initial begin
    logic [31:0] d [9];
    logic [11:0] addrs [4];
    int got, cyc;

    #12;
    check_reset_outputs("rst");
    nrst = 1'b1;
    step();
    chk("idle_wvalid", o_wvalid, 0);

    run_xfer(8, 100, 100);
    run_xfer(6, 100, 100);
    run_xfer(5, 40, 100);
    for (int t = 0; t < 10; t++)
      run_xfer($urandom_range(1, 40), $urandom_range(30, 100), $urandom_range(30, 100));
    run_xfer(4095, 100, 100);

    // Overflow: stalled sink, nine pushes into an eight-entry buffer
    start_xfer(8);
    i_wready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d[i] = $urandom;
      i_res_valid = 1'b1;
      i_res_data  = d[i];
      i_res_addr  = 12'(i);
      step();
      if (i == 7) begin
        chk("ovf_ready_full", o_res_ready, 0);
        chk("ovf_not_yet", o_overflow, 0);
      end
    end
    i_res_valid = 1'b0;
    chk("ovf_set", o_overflow, 1);
    i_wready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 40) begin
      if (o_wvalid) begin
        chk("ovf_data", o_wdata, d[got]);
        got++;
      end
      step();
      cyc++;
    end
    chk("ovf_beats", got, 8);
    chk("ovf_done", o_done, 1);
    chk("ovf_ready_back", o_res_ready, 1);

    // Address sequence 0,1,3
    addrs[0] = 12'd0; addrs[1] = 12'd1; addrs[2] = 12'd3; addrs[3] = 12'd3;
    start_xfer(4);
    chk("start_clears_ovf", o_overflow, 0);
    i_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_res_valid = 1'b1;
      i_res_data  = 32'(i);
      i_res_addr  = addrs[i];
      step();
      if (i == 1) chk("seq_ok", o_seq_err, 0);
      if (i == 2) chk("seq_err", o_seq_err, SEQ_EXP);
    end
    i_res_valid = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 30) begin
      step();
      cyc++;
    end
    chk("seq_done", o_done, 1);
    chk("seq_sticky", o_seq_err, SEQ_EXP);
    start_xfer(0);
    chk("seq_cleared", o_seq_err, 0);
    chk("zero_done", o_done, 1);

    // Reset during beat 2
    start_xfer(8);
    i_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_res_valid = 1'b1;
      i_res_data  = 32'hA000 + 32'(i);
      step();
    end
    i_res_valid = 1'b0;
    cyc = 0;
    while (!o_wvalid && cyc < 10) begin
      step();
      cyc++;
    end
    chk("rb_beat1", o_wdata, 32'hA000);
    step();
    chk("rb_beat2", o_wburst, 2);
    #2 nrst = 1'b0;
    #1 check_reset_outputs("midrst");
    #2 nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wvalid", o_wvalid, 0);
    end
    start_xfer(0);
    chk("rst_zero_done", o_done, 1);
    chk("rst_zero_wvalid", o_wvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
